mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one single-port unified memory between the 5-stage CPU's instruction-fetch port (IF) and its load/store port (MEM stage).
- Arbitrates requests, sequences the memory's fixed read latency and returns read data to the correct requester.
- Applies back-pressure through ready signals so the pipeline stalls while the memory is busy.
- Data requests take priority; a streak counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, address width, passed through unchanged.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from memory read command to valid mem_rdata_i. Must be >= 1.
- MAX_STREAK, 4, maximum consecutive data grants while a fetch is pending. Must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held with address until accepted.
- if_addr_i  in  ADDR_W  fetch address.
- if_ready_o  out  1  fetch accepted this cycle (req & ready = handshake).
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched instruction; holds until the next fetch response.
- dm_req_i  in  1  data request; held until accepted.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_ready_o  out  1  data request accepted this cycle.
- dm_rvalid_o  out  1  one-cycle pulse; dm_rdata_o valid (loads only).
- dm_rdata_o  out  DATA_W  load data; holds until the next load response.
- mem_en_o  out  1  memory command strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid RD_LAT cycles after a read command.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: state IDLE, lat_cnt = 0, streak = 0, owner = IF.
  - All *_ready_o, *_rvalid_o and mem_en_o/mem_we_o are 0.
  - if_rdata_o, dm_rdata_o, mem_addr_o and mem_wdata_o are 0.
- FSM states:
  - IDLE: arbitrate. On a read grant go to WAIT; on a write grant stay in IDLE. No request: stay in IDLE.
  - WAIT: lat_cnt counts 1..RD_LAT. After the cycle with lat_cnt == RD_LAT, capture mem_rdata_i into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's rvalid_o, then behave exactly as IDLE in the same cycle. Arbitration and a new grant are allowed, so back-to-back reads are supported.
- Arbitration (IDLE/RESP only; combinational grant):
  - dm only: grant dm. if only: grant if.
  - Both requesting: grant dm unless streak == MAX_STREAK, in which case grant if.
  - streak increments on a dm grant while if_req_i = 1 (saturates at MAX_STREAK). It clears on any if grant, and clears when if_req_i = 0 in IDLE.
- Grant cycle:
  - The granted ready_o = 1; the other ready_o = 0.
  - mem_en_o = 1, and mem_addr_o/mem_we_o/mem_wdata_o come from the winner (combinational).
  - owner is registered on the grant.
- No requester ever has ready_o = 1 in WAIT.
- mem_en_o = 0 whenever there is no grant.
- Stores: complete in the grant cycle; no rvalid is issued.
- Fetches: mem_we_o = 0 always.
- Read latency: accepted in cycle t, mem_rdata_i sampled at the end of cycle t+RD_LAT, rvalid_o high in cycle t+RD_LAT+1. Read throughput is one read per RD_LAT+1 cycles.
- Simultaneous events: in the RESP cycle, a new grant and the rvalid pulse of the previous read coexist. An rvalid goes only to the previous owner.
- Request withdrawn before acceptance: protocol violation; behaviour is undefined. Arbitration still uses only the current-cycle inputs.
- Reset mid-operation (WAIT or RESP): return to IDLE next cycle.
  - The pending response is discarded; no rvalid is issued.
  - Both rdata registers clear to 0.
- Address, data and widths are passed through unchanged; there is no alignment check.

Test Plan:
1. Reset with rst = 1 for 3 cycles while if_req_i = dm_req_i = 1 -> all ready/rvalid/mem_en outputs are 0 and rdata = 0.
2. Single fetch, RD_LAT = 1: if_addr = 0x8, memory returns 0x8C020001 -> if_ready high in cycle t, mem_en = 1 and mem_addr = 0x8 in cycle t, if_rvalid high only in t+2, if_rdata = 0x8C020001.
3. Collision: if_req and a dm load (addr 0x1) asserted together -> dm granted first, dm_rvalid returns mem[1] = 5 at t+2. The fetch is granted in the RESP cycle t+2, and its rvalid arrives at t+4.
4. Starvation, MAX_STREAK = 4: dm_req held high with stores, if_req held high -> exactly 4 consecutive dm grants, then an if grant, then streak restarts at 0.
5. Back-to-back stores: dm stores to 0x3 with data 6, then 0x4 with data 7 -> dm_ready high on consecutive cycles, mem_we = 1 each cycle, no rvalid, busy_o stays 0.
6. rst asserted in WAIT with RD_LAT = 3 -> no rvalid ever issued for that read, state is IDLE next cycle, and a new fetch is accepted in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mips_mem_arbiter                                                         |
// | Shares one single-port memory between the CPU fetch and load/store      |
// | ports; data has priority, a streak limit guarantees fetch progress.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,

  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  localparam int c_LAT_W = $clog2(RD_LAT + 1);
  localparam int c_STK_W = $clog2(MAX_STREAK + 1);

  localparam logic [c_LAT_W-1:0] c_LAT_MAX = c_LAT_W'(RD_LAT);
  localparam logic [c_LAT_W-1:0] c_LAT_ONE = c_LAT_W'(1);
  localparam logic [c_STK_W-1:0] c_STK_MAX = c_STK_W'(MAX_STREAK);
  localparam logic [c_STK_W-1:0] c_STK_ONE = c_STK_W'(1);

  localparam logic c_OWN_IF = 1'b0;
  localparam logic c_OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_LAT_W-1:0]  r_lat_cnt;
  logic [c_LAT_W-1:0]  w_lat_cnt_nxt;
  logic [c_STK_W-1:0]  r_streak;
  logic [c_STK_W-1:0]  w_streak_nxt;
  logic                r_owner;
  logic                w_owner_nxt;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_arb_en;
  logic                w_grant_if;
  logic                w_grant_dm;
  logic                w_grant_rd;
  logic                w_capture;

  // Reset masks the grant so nothing is accepted while rst is high.
  always_comb begin
    w_arb_en   = !rst && (r_state != ST_WAIT);
    w_grant_dm = w_arb_en && dm_req_i && (!if_req_i || (r_streak != c_STK_MAX));
    w_grant_if = w_arb_en && if_req_i && !w_grant_dm;
    w_grant_rd = w_grant_if || (w_grant_dm && !dm_we_i);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_streak_nxt  = r_streak;
    w_owner_nxt   = r_owner;
    w_capture     = 1'b0;

    case (r_state)
      ST_WAIT: begin
        if (r_lat_cnt == c_LAT_MAX) begin
          w_capture     = 1'b1;
          w_state_nxt   = ST_RESP;
          w_lat_cnt_nxt = '0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + c_LAT_ONE;
        end
      end
      default: begin
        // RESP arbitrates exactly like IDLE, enabling back-to-back reads.
        w_state_nxt = ST_IDLE;
        if (w_grant_rd) begin
          w_state_nxt   = ST_WAIT;
          w_lat_cnt_nxt = c_LAT_ONE;
        end
      end
    endcase

    if (w_grant_if) begin
      w_owner_nxt = c_OWN_IF;
    end else if (w_grant_dm) begin
      w_owner_nxt = c_OWN_DM;
    end

    if (w_grant_if) begin
      w_streak_nxt = '0;
    end else if (w_grant_dm && if_req_i) begin
      if (r_streak != c_STK_MAX) begin
        w_streak_nxt = r_streak + c_STK_ONE;
      end
    end else if ((r_state == ST_IDLE) && !if_req_i) begin
      w_streak_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= '0;
      r_streak   <= '0;
      r_owner    <= c_OWN_IF;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_streak  <= w_streak_nxt;
      r_owner   <= w_owner_nxt;
      if (w_capture && (r_owner == c_OWN_IF)) begin
        r_if_rdata <= mem_rdata_i;
      end
      if (w_capture && (r_owner == c_OWN_DM)) begin
        r_dm_rdata <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    if_ready_o  = w_grant_if;
    dm_ready_o  = w_grant_dm;
    mem_en_o    = w_grant_if || w_grant_dm;
    mem_we_o    = w_grant_dm && dm_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_grant_dm) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (w_grant_if) begin
      mem_addr_o  = if_addr_i;
    end
    if_rvalid_o = !rst && (r_state == ST_RESP) && (r_owner == c_OWN_IF);
    dm_rvalid_o = !rst && (r_state == ST_RESP) && (r_owner == c_OWN_DM);
    if_rdata_o  = r_if_rdata;
    dm_rdata_o  = r_dm_rdata;
    busy_o      = (r_state != ST_IDLE);
  end

endmodule

`default_nettype wire
